// File: rtl/ntt_sram_stream_master.sv
// rtl/ntt_sram_stream_master.sv - coefficient SRAM block mover between the SRAM and valid/ready streams
// Read mode drains SRAM into m_*, write mode fills SRAM from s_*; one contiguous block per start.
module ntt_sram_stream_master #(
  parameter int AddrWidth = 10,
  parameter int LenWidth  = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 dir_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  input  logic [31:0]          sram_rdata_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [31:0]          m_data_o,
  output logic                 m_last_o,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [31:0]          s_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 dir_q;
  logic [AddrWidth-1:0] base_q;
  logic [LenWidth-1:0]  len_q;
  logic [LenWidth-1:0]  cnt_q;      // words written (write) or reads issued (read)
  logic [LenWidth-1:0]  pop_cnt_q;  // words handed out on m_*; index of the FIFO head
  logic                 inflight_q;
  logic [31:0]          fifo_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           fifo_cnt_q;

  logic                 fifo_nonempty;
  logic                 pop;
  logic                 cnt_lt_len;
  logic [2:0]           occupancy;
  logic                 rd_issue;
  logic                 wr_fire;
  logic                 head_is_last;
  logic [AddrWidth-1:0] cur_addr;

  assign fifo_nonempty = (fifo_cnt_q != 2'd0);
  assign pop           = fifo_nonempty & m_ready_i;
  assign cnt_lt_len    = (cnt_q < len_q);
  assign head_is_last  = (pop_cnt_q == len_q - LenWidth'(1));
  assign cur_addr      = base_q + cnt_q[AddrWidth-1:0];

  // Slots already claimed once this cycle's pop retires; keeps SRAM data from overrunning the FIFO.
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue  = (state_q == RUN) & ~dir_q & cnt_lt_len & (occupancy < 3'd2);
  assign wr_fire   = (state_q == RUN) & dir_q & cnt_lt_len & s_valid_i;

  assign busy_o    = (state_q != IDLE);
  assign m_valid_o = fifo_nonempty;
  assign m_data_o  = fifo_q[rd_ptr_q];
  assign m_last_o  = fifo_nonempty & head_is_last;

  always_comb begin
    state_d      = state_q;
    done_o       = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = 4'h0;
    s_ready_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (dir_q) begin
          s_ready_o = cnt_lt_len;
          if (wr_fire) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_be_o    = 4'hF;
            sram_wdata_o = s_data_i;
            sram_addr_o  = cur_addr;
            if (cnt_q == len_q - LenWidth'(1)) begin
              state_d = DONE;
            end
          end
        end else begin
          if (rd_issue) begin
            sram_req_o  = 1'b1;
            sram_addr_o = cur_addr;
          end
          if (pop && head_is_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        dir_q     <= dir_i;
        base_q    <= base_addr_i;
        len_q     <= len_i;
        cnt_q     <= '0;
        pop_cnt_q <= '0;
      end else if (wr_fire || rd_issue) begin
        cnt_q <= cnt_q + LenWidth'(1);
      end
      if (pop) begin
        pop_cnt_q <= pop_cnt_q + LenWidth'(1);
        rd_ptr_q  <= ~rd_ptr_q;
      end
      // Read data returns one cycle after issue and lands in the FIFO tail.
      inflight_q <= rd_issue;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= sram_rdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ntt_sram_stream_master.sv
// tb/tb_ntt_sram_stream_master.sv - self-checking bench for ntt_sram_stream_master
// Behavioural SRAM plus per-transfer reference models built from word order and cycle timing.
module tb_ntt_sram_stream_master;
  localparam int AW = 10;
  localparam int LW = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_be;
  logic [31:0]   sram_rdata = '0;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;

  logic [31:0] mem [DEPTH];
  int n_assert = 0;
  int n_fail = 0;

  ntt_sram_stream_master #(.AddrWidth(AW), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir),
    .base_addr_i(base_addr), .len_i(len), .busy_o(busy), .done_o(done),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_req && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_req && !sram_we) sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, sram_req, 0);
    chk({tag, "_we"}, sram_we, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_be"}, sram_be, 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_sready"}, s_ready, 0);
  endtask

  // Leaves the caller at the falling edge inside cycle T+1.
  task automatic do_start(input bit d, input int b, input int l);
    @(negedge clk);
    start = 1'b1; dir = d; base_addr = AW'(b); len = LW'(l);
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_write(input int b, input int l, input int pct, input bit stray);
    logic [31:0] data[$];
    int k = 0, done_cyc = -1, c = 1, last_wr = -1;
    bit exp_ready, exp_busy;
    for (int i = 0; i < l; i++) data.push_back($urandom);
    do_start(1'b1, b, l);
    if (l == 0) done_cyc = 1;
    while (1) begin
      s_valid = ($urandom_range(99) < pct);
      s_data = (k < l) ? data[k] : $urandom;
      if (stray && c == 2) begin
        start = 1'b1; dir = 1'b0; len = LW'(3);
      end
      #1;
      exp_busy  = (done_cyc < 0) || (c <= done_cyc);
      exp_ready = (done_cyc < 0) && (k < l);
      chk("wr_busy", busy, exp_busy);
      chk("wr_done", done, (c == done_cyc));
      chk("wr_sready", s_ready, exp_ready);
      chk("wr_mvalid", m_valid, 0);
      if (exp_ready && s_valid) begin
        chk("wr_req", sram_req, 1);
        chk("wr_we", sram_we, 1);
        chk("wr_be", sram_be, 4'hF);
        chk("wr_addr", sram_addr, (b + k) % DEPTH);
        chk("wr_wdata", sram_wdata, data[k]);
        k++;
        if (k == l) begin
          done_cyc = c + 1;
          last_wr = c;
        end
      end else begin
        chk("wr_noreq", sram_req, 0);
      end
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      @(negedge clk);
      start = 1'b0;
      c++;
      if (c > 4 * l + 50) begin
        chk("wr_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    chk("wr_count", k, l);
    if (pct == 100 && l > 0) chk("wr_last_cycle", last_wr, l);
    @(negedge clk);
    for (int i = 0; i < l; i++) chk("wr_mem", mem[(b + i) % DEPTH], data[i]);
  endtask

  task automatic run_read(input int b, input int l, input int pct, input int rst_after);
    logic [31:0] exp_q[$];
    int iss = 0, pop_n = 0, done_cyc = -1, c = 1;
    bit pop_now, exp_busy;
    for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    do_start(1'b0, b, l);
    if (l == 0) done_cyc = 1;
    while (1) begin
      m_ready = ($urandom_range(99) < pct);
      #1;
      exp_busy = (done_cyc < 0) || (c <= done_cyc);
      chk("rd_busy", busy, exp_busy);
      chk("rd_done", done, (c == done_cyc));
      chk("rd_sready", s_ready, 0);
      pop_now = m_valid && m_ready;
      if (m_valid) chk("rd_last", m_last, (pop_n == l - 1));
      else chk("rd_last_idle", m_last, 0);
      if (pop_now) begin
        if (pop_n < l) chk("rd_data", m_data, exp_q[pop_n]);
        else chk("rd_extra_word", 1, 0);
      end
      if (sram_req) begin
        chk("rd_we", sram_we, 0);
        chk("rd_be", sram_be, 0);
        chk("rd_addr", sram_addr, (b + iss) % DEPTH);
        chk("rd_window", ((iss - pop_n - int'(pop_now)) < 2), 1);
        chk("rd_overissue", (iss < l), 1);
        iss++;
      end
      if (pct == 100) begin
        chk("rd_req_timing", sram_req, (c <= l));
        chk("rd_valid_timing", m_valid, (c >= 3 && c <= l + 2));
      end
      if (pop_now) begin
        pop_n++;
        if (pop_n == l) done_cyc = c + 1;
      end
      if (rst_after >= 0 && pop_n == rst_after) begin
        @(negedge clk);
        rst = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        return;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      @(negedge clk);
      c++;
      if (c > 6 * l + 50) begin
        chk("rd_timeout", 0, 1);
        break;
      end
    end
    m_ready = 1'b0;
    chk("rd_pop_count", pop_n, l);
    chk("rd_issue_count", iss, l);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_write(32'h3FE, 4, 100, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = i * 3;
    run_read(32'h010, 8, 100, -1);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int t = 0; t < 4; t++) begin
      run_read(int'($urandom_range(DEPTH - 1)), (t == 0) ? 6 : int'($urandom_range(1, 12)), 50, -1);
    end

    run_write(32'h000, 0, 100, 1'b0);
    run_read(32'h100, 0, 100, -1);

    run_read(32'h020, 8, 100, 3);
    run_read(32'h3FF, 2, 100, -1);

    run_write(32'h200, 5, 100, 1'b1);
    run_read(32'h200, 5, 100, -1);
    run_write(int'($urandom_range(DEPTH - 1)), 7, 60, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ntt_sram_stream_master.md
Name: ntt_sram_stream_master

Overview:
- Initiator side of the single-port coefficient SRAM interface (req/we/addr/wdata/be/rdata, 1-cycle read latency) used by the NTT/INTT/PWM memories.
- Moves a contiguous block of 32-bit words in one of two directions:
  - SRAM → valid/ready output stream (read mode).
  - Valid/ready input stream → SRAM (write mode).
- Lets the accelerator datapath load and unload polynomial banks without a CPU in the loop.

Parameters:
- AddrWidth, 10, SRAM word-address width.
- LenWidth, 11, transfer-length counter width; the maximum length is 2^AddrWidth words.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse; begins a transfer; sampled only in IDLE
- dir_i  in  1  0 = read (SRAM→m_*), 1 = write (s_*→SRAM); sampled with start_i
- base_addr_i  in  AddrWidth  first word address; sampled with start_i
- len_i  in  LenWidth  number of words; sampled with start_i
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle pulse at transfer end
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_be_o  out  4  byte enable; always 4'hF when writing, 4'h0 otherwise
- sram_rdata_i  in  32  SRAM read data, valid the cycle after a read req
- m_valid_o  out  1  output stream valid
- m_ready_i  in  1  output stream ready
- m_data_o  out  32  output stream data
- m_last_o  out  1  marks final word of a read transfer
- s_valid_i  in  1  input stream valid
- s_ready_o  out  1  input stream ready
- s_data_i  in  32  input stream data

Behaviour:
- Reset:
  - rst_i high at a clock edge → state IDLE, all counters 0, FIFO emptied, any in-flight read discarded.
  - Outputs after reset: busy_o=0, done_o=0, sram_req_o=0, sram_we_o=0, sram_addr_o=0, sram_be_o=0, sram_wdata_o=0, m_valid_o=0, m_last_o=0, s_ready_o=0.
  - Reset mid-transfer aborts the transfer with no done_o.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start_i in cycle T: latch dir, base, len; clear counters.
  - start_i with len_i=0: go IDLE→DONE directly; done_o high in T+1; no SRAM access.
  - RUN→DONE when the final word completes (write: last write issued; read: last m_* handshake).
  - DONE→IDLE after one cycle. done_o=1 exactly in DONE.
  - start_i outside IDLE is ignored.
- Address rule: word k uses address (base + k) mod 2^AddrWidth; wraps silently past the top.
- Write mode:
  - s_ready_o = RUN & dir & (written < len).
  - On s_valid_i & s_ready_o (combinational): sram_req_o=1, sram_we_o=1, sram_be_o=4'hF, sram_wdata_o=s_data_i, sram_addr_o = base+written; written increments.
  - No request on cycles without a handshake. Throughput 1 word/cycle.
  - First s_ready_o in T+1. With s_valid_i held high, last write in T+len and done_o in T+len+1.
- Read mode:
  - Uses an internal 2-entry FIFO plus an in-flight flag (a read issued in the previous cycle).
  - Read issue (sram_req_o=1, sram_we_o=0) when RUN & issued < len & (fifo_count + inflight − pop_this_cycle) < 2. This guarantees SRAM data never overflows the FIFO.
  - sram_rdata_i is written into the FIFO in the cycle after issue.
  - m_valid_o = FIFO non-empty; m_data_o = FIFO head (registered).
  - m_last_o = m_valid_o & (head is word len−1).
  - Pop on m_valid_o & m_ready_i. Simultaneous push and pop are allowed.
  - With m_ready_i held high: first req at T+1, first m_valid_o at T+3, 1 word/cycle, last handshake at T+len+2, done_o at T+len+3.
  - When m_ready_i is low, issue stalls once the FIFO plus in-flight reach 2. No data is lost, duplicated or reordered.
- sram_addr_o, sram_wdata_o and sram_we_o are don't-care when sram_req_o=0. For determinism they hold 0 in IDLE.

Test Plan:
- Write mode: base=0x3FE, len=4, s_valid_i=1 with data 0xA0..0xA3 → four writes in T+1..T+4 at addresses 0x3FE, 0x3FF, 0x000, 0x001 with be=4'hF; done_o at T+5 only.
- Read mode: base=0x010, len=8, m_ready_i=1, SRAM preloaded with word[i]=i*3 → m_data_o = 0x30..0x45 pattern (word 16+k) in T+3..T+10; m_last_o only at T+10; done_o at T+11.
- Read backpressure: len=6, m_ready_i toggling 1,0,0,1,… randomly → output sequence identical to the SRAM contents in order; at most 2 outstanding reads; never a req while FIFO+inflight=2 and no pop.
- len=0 in both directions → no sram_req_o; done_o in T+1; busy_o high for exactly 1 cycle.
- rst_i asserted mid read transfer (after 3 words) → next cycle all outputs at reset values; a new start_i with len=2 completes correctly with no stale data.
- start_i pulsed while busy (write, len=5) → ignored; exactly 5 writes and one done_o.
